// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz buzzer round controller: FSM state codes,
// player identifiers and score geometry.
package quiz_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_ANSWER = 3'd2;
    localparam logic [2:0] ST_CLEAR  = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    localparam int NUM_PLAYERS = 4;
    localparam int SCORE_W     = 4;

    localparam logic [3:0] PLAYER_NONE = 4'd0;
    localparam logic [3:0] PLAYER_1    = 4'd1;
    localparam logic [3:0] PLAYER_4    = 4'd4;

    // A selector report is only usable when it names one of the real players.
    function automatic logic player_valid(input logic [3:0] p);
        return (p >= PLAYER_1) && (p <= PLAYER_4);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler for the answer countdown. Counts 0..TICK_DIV-1 and
// raises tick for the single cycle in which the count sits at its top value.
// A synchronous clear parks the count at zero so every round starts a fresh
// second.
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running prescaler, held at zero while cleared, wrapping at the top.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the 4-player quiz buzzer. Arms and clears the player
// selector, runs the per-round answer countdown, applies host judgements to
// the player scores and detects the end of the game.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ANSWER_SEC = 10,
    parameter int SCORE_MAX  = 9,
    parameter int CLR_CYC    = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Host_Start,
    input  logic                           Host_Correct,
    input  logic                           Host_Wrong,
    input  logic                           Host_Clear,
    input  logic                           Sel_Lock,
    input  logic [3:0]                     Sel_Player,
    output logic                           Sel_Start,
    output logic                           Sel_RSTn,
    output logic [2:0]                     Round_State,
    output logic [3:0]                     Cur_Player,
    output logic [3:0]                     Sec_Left,
    output logic [NUM_PLAYERS*SCORE_W-1:0] Score,
    output logic [7:0]                     Round_Cnt,
    output logic                           Game_Over,
    output logic [3:0]                     Winner
);

    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam logic [CLR_W-1:0]   CLR_LOAD  = CLR_W'(CLR_CYC);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
    localparam logic [3:0]         SEC_LOAD  = 4'(ANSWER_SEC);

    logic [2:0]                     state;
    logic [2:0]                     state_d;
    logic [CLR_W-1:0]               clr_cnt;
    logic [NUM_PLAYERS*SCORE_W-1:0] score_d;
    logic [7:0]                     round_d;
    logic [3:0]                     cur_d;
    logic [3:0]                     sec_d;
    logic [1:0]                     pidx;
    logic [SCORE_W-1:0]             cur_score;
    logic [SCORE_W-1:0]             new_score;
    logic                           tick;
    logic                           single_judge;
    logic                           expiry;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state != ST_ANSWER),
        .tick (tick)
    );

    assign Round_State  = state;
    assign single_judge = Host_Correct ^ Host_Wrong;
    assign expiry       = tick && (Sec_Left == 4'd1);

    // Next-state and datapath decisions; Host_Clear beats any judgement, and a
    // lone judgement beats a coincident expiry because it is checked first.
    always_comb begin
        state_d   = state;
        score_d   = Score;
        round_d   = Round_Cnt;
        cur_d     = Cur_Player;
        sec_d     = Sec_Left;
        pidx      = 2'(Cur_Player - 4'd1);
        cur_score = Score[pidx*SCORE_W +: SCORE_W];
        new_score = cur_score;
        case (state)
            ST_IDLE: begin
                if (Host_Start) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (Host_Clear) begin
                    state_d = ST_CLEAR;
                end else if (Sel_Lock) begin
                    if (player_valid(Sel_Player)) begin
                        state_d = ST_ANSWER;
                        cur_d   = Sel_Player;
                        sec_d   = SEC_LOAD;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_ANSWER: begin
                if (Host_Clear) begin
                    state_d = ST_CLEAR;
                end else if (single_judge || expiry) begin
                    if (single_judge && Host_Correct) begin
                        new_score = (cur_score == SCORE_TOP) ? cur_score : cur_score + SCORE_W'(1);
                    end else begin
                        new_score = (cur_score == '0) ? cur_score : cur_score - SCORE_W'(1);
                    end
                    score_d[pidx*SCORE_W +: SCORE_W] = new_score;
                    round_d = Round_Cnt + 8'd1;
                    state_d = (new_score == SCORE_TOP) ? ST_OVER : ST_CLEAR;
                end else if (tick) begin
                    sec_d = Sec_Left - 4'd1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt <= CLR_W'(1)) state_d = ST_IDLE;
            end
            ST_OVER: begin
                if (Host_Clear) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (state_d == ST_CLEAR) cur_d = PLAYER_NONE;
        if ((state_d == ST_CLEAR) || (state_d == ST_OVER)) sec_d = '0;
    end

    // State, scores and all outputs are registered from the next-state view so
    // selector controls change in the same cycle as the state they belong to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_CLEAR;
            clr_cnt    <= CLR_LOAD;
            Sel_Start  <= 1'b0;
            Sel_RSTn   <= 1'b0;
            Cur_Player <= PLAYER_NONE;
            Sec_Left   <= '0;
            Score      <= '0;
            Round_Cnt  <= '0;
            Game_Over  <= 1'b0;
            Winner     <= PLAYER_NONE;
        end else begin
            state      <= state_d;
            Score      <= score_d;
            Round_Cnt  <= round_d;
            Cur_Player <= cur_d;
            Sec_Left   <= sec_d;
            Sel_Start  <= (state_d == ST_ARMED) || (state_d == ST_ANSWER);
            Sel_RSTn   <= (state_d != ST_CLEAR);
            Game_Over  <= (state_d == ST_OVER);
            Winner     <= (state_d == ST_OVER) ? cur_d : PLAYER_NONE;
            if ((state != ST_CLEAR) && (state_d == ST_CLEAR)) begin
                clr_cnt <= CLR_LOAD;
            end else if ((state == ST_CLEAR) && (clr_cnt != '0)) begin
                clr_cnt <= clr_cnt - CLR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with a small configuration
// (TICK_DIV=4, ANSWER_SEC=3, SCORE_MAX=2, CLR_CYC=2). The selector is
// played by the bench through Sel_Lock/Sel_Player.
module tb_quiz_round_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Host_Start = 1'b0;
    logic        Host_Correct = 1'b0;
    logic        Host_Wrong = 1'b0;
    logic        Host_Clear = 1'b0;
    logic        Sel_Lock = 1'b0;
    logic [3:0]  Sel_Player = 4'd0;
    logic        Sel_Start;
    logic        Sel_RSTn;
    logic [2:0]  Round_State;
    logic [3:0]  Cur_Player;
    logic [3:0]  Sec_Left;
    logic [15:0] Score;
    logic [7:0]  Round_Cnt;
    logic        Game_Over;
    logic [3:0]  Winner;

    int total = 0;
    int bad = 0;

    quiz_round_ctrl #(
        .TICK_DIV   (4),
        .ANSWER_SEC (3),
        .SCORE_MAX  (2),
        .CLR_CYC    (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Host_Start   (Host_Start),
        .Host_Correct (Host_Correct),
        .Host_Wrong   (Host_Wrong),
        .Host_Clear   (Host_Clear),
        .Sel_Lock     (Sel_Lock),
        .Sel_Player   (Sel_Player),
        .Sel_Start    (Sel_Start),
        .Sel_RSTn     (Sel_RSTn),
        .Round_State  (Round_State),
        .Cur_Player   (Cur_Player),
        .Sec_Left     (Sec_Left),
        .Score        (Score),
        .Round_Cnt    (Round_Cnt),
        .Game_Over    (Game_Over),
        .Winner       (Winner)
    );

    // 100 MHz free-running clock.
    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive the host pulse inputs for exactly one sampled cycle.
    task automatic applyStimulus(input logic s, input logic c, input logic w, input logic clr);
        Host_Start   = s;
        Host_Correct = c;
        Host_Wrong   = w;
        Host_Clear   = clr;
        tick();
        Host_Start   = 1'b0;
        Host_Correct = 1'b0;
        Host_Wrong   = 1'b0;
        Host_Clear   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Selector releases its latch, then two clear cycles lead back to IDLE.
    task automatic finishClear(input string tag);
        Sel_Lock   = 1'b0;
        Sel_Player = 4'd0;
        checkOutput({tag, "_clr_rstn0"}, 16'(Sel_RSTn), 16'd0);
        tick();
        checkOutput({tag, "_clr_rstn1"}, 16'(Sel_RSTn), 16'd0);
        tick();
        checkOutput({tag, "_idle_state"}, 16'(Round_State), 16'd0);
        checkOutput({tag, "_idle_rstn"}, 16'(Sel_RSTn), 16'd1);
    endtask

    // Open a round and let the selector lock onto a player.
    task automatic openRound(input logic [3:0] player);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        Sel_Lock   = 1'b1;
        Sel_Player = player;
        tick();
    endtask

    initial begin
        // Reset held across clock edges.
        RST = 1'b1;
        tick();
        tick();
        checkOutput("rst_state", 16'(Round_State), 16'd3);
        checkOutput("rst_rstn", 16'(Sel_RSTn), 16'd0);
        checkOutput("rst_start", 16'(Sel_Start), 16'd0);
        checkOutput("rst_score", Score, 16'h0000);
        RST = 1'b0;
        tick();
        checkOutput("rel_clr1_state", 16'(Round_State), 16'd3);
        checkOutput("rel_clr1_rstn", 16'(Sel_RSTn), 16'd0);
        tick();
        checkOutput("rel_idle_state", 16'(Round_State), 16'd0);
        checkOutput("rel_idle_rstn", 16'(Sel_RSTn), 16'd1);
        checkOutput("rel_idle_start", 16'(Sel_Start), 16'd0);
        checkOutput("rel_idle_cur", 16'(Cur_Player), 16'd0);
        checkOutput("rel_idle_sec", 16'(Sec_Left), 16'd0);
        checkOutput("rel_idle_rcnt", 16'(Round_Cnt), 16'd0);
        checkOutput("rel_idle_over", 16'(Game_Over), 16'd0);
        checkOutput("rel_idle_win", 16'(Winner), 16'd0);

        // Player 3 answers correctly.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("p3_armed_state", 16'(Round_State), 16'd1);
        checkOutput("p3_armed_start", 16'(Sel_Start), 16'd1);
        Sel_Lock   = 1'b1;
        Sel_Player = 4'd3;
        tick();
        checkOutput("p3_ans_state", 16'(Round_State), 16'd2);
        checkOutput("p3_ans_cur", 16'(Cur_Player), 16'd3);
        checkOutput("p3_ans_sec", 16'(Sec_Left), 16'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("p3_clr_state", 16'(Round_State), 16'd3);
        checkOutput("p3_score", Score, 16'h0100);
        checkOutput("p3_rcnt", 16'(Round_Cnt), 16'd1);
        checkOutput("p3_clr_start", 16'(Sel_Start), 16'd0);
        checkOutput("p3_clr_cur", 16'(Cur_Player), 16'd0);
        finishClear("p3");

        // Player 2 lets the countdown expire; score saturates at zero.
        openRound(4'd2);
        checkOutput("exp_sec3", 16'(Sec_Left), 16'd3);
        repeat (4) tick();
        checkOutput("exp_sec2", 16'(Sec_Left), 16'd2);
        repeat (4) tick();
        checkOutput("exp_sec1", 16'(Sec_Left), 16'd1);
        repeat (3) tick();
        checkOutput("exp_c11_state", 16'(Round_State), 16'd2);
        tick();
        checkOutput("exp_c12_state", 16'(Round_State), 16'd3);
        checkOutput("exp_score", Score, 16'h0100);
        checkOutput("exp_rcnt", 16'(Round_Cnt), 16'd2);
        checkOutput("exp_sec0", 16'(Sec_Left), 16'd0);
        finishClear("exp");

        // Simultaneous correct+wrong is ignored; a lone correct then lands.
        openRound(4'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_state", 16'(Round_State), 16'd2);
        checkOutput("both_score", Score, 16'h0100);
        checkOutput("both_rcnt", 16'(Round_Cnt), 16'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_state", 16'(Round_State), 16'd3);
        checkOutput("after_score", Score, 16'h0101);
        checkOutput("after_rcnt", 16'(Round_Cnt), 16'd3);
        finishClear("after");

        // Player 3 answers wrong: 1 drops to 0.
        openRound(4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrong_score", Score, 16'h0001);
        checkOutput("wrong_rcnt", 16'(Round_Cnt), 16'd4);
        finishClear("wrong");

        // Fresh game: player 1 correct twice reaches the winning score.
        RST = 1'b1;
        #1;
        checkOutput("rst2_score", Score, 16'h0000);
        tick();
        RST = 1'b0;
        tick();
        tick();
        checkOutput("rst2_idle", 16'(Round_State), 16'd0);
        openRound(4'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("win1_score", Score, 16'h0001);
        finishClear("win1");
        openRound(4'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("over_state", 16'(Round_State), 16'd4);
        checkOutput("over_flag", 16'(Game_Over), 16'd1);
        checkOutput("over_winner", 16'(Winner), 16'd1);
        checkOutput("over_score", Score, 16'h0002);
        checkOutput("over_rcnt", 16'(Round_Cnt), 16'd2);
        checkOutput("over_rstn", 16'(Sel_RSTn), 16'd1);
        checkOutput("over_start", 16'(Sel_Start), 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("over_ign_state", 16'(Round_State), 16'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("newgame_state", 16'(Round_State), 16'd3);
        checkOutput("newgame_score", Score, 16'h0000);
        checkOutput("newgame_rcnt", 16'(Round_Cnt), 16'd0);
        checkOutput("newgame_over", 16'(Game_Over), 16'd0);
        checkOutput("newgame_win", 16'(Winner), 16'd0);
        finishClear("newgame");

        // Invalid lock goes straight to CLEAR.
        openRound(4'd0);
        checkOutput("inv_state", 16'(Round_State), 16'd3);
        checkOutput("inv_score", Score, 16'h0000);
        checkOutput("inv_rcnt", 16'(Round_Cnt), 16'd0);
        finishClear("inv");

        // Player 4 scores, then reset is pulsed mid-answer.
        openRound(4'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("p4_score", Score, 16'h1000);
        finishClear("p4");
        openRound(4'd2);
        tick();
        checkOutput("mid_state", 16'(Round_State), 16'd2);
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_state", 16'(Round_State), 16'd3);
        checkOutput("mid_rst_rstn", 16'(Sel_RSTn), 16'd0);
        checkOutput("mid_rst_start", 16'(Sel_Start), 16'd0);
        checkOutput("mid_rst_cur", 16'(Cur_Player), 16'd0);
        checkOutput("mid_rst_sec", 16'(Sec_Left), 16'd0);
        checkOutput("mid_rst_score", Score, 16'h0000);
        checkOutput("mid_rst_rcnt", 16'(Round_Cnt), 16'd0);
        Sel_Lock   = 1'b0;
        Sel_Player = 4'd0;
        tick();
        RST = 1'b0;
        tick();
        tick();
        checkOutput("final_idle", 16'(Round_State), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round sequencer for the 4-player quiz buzzer. Sits above the player-select block: it arms and clears that block, runs the per-round answer countdown, applies host judgements to per-player scores and detects end of game. The selector's Start input is driven from Sel_Start and its RSTn input from Sel_RSTn; the selector's Timer_Start and Player_Number outputs return here.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per countdown second (1 s at 50 MHz).
- ANSWER_SEC, 10: answer window in seconds, 1..15.
- SCORE_MAX, 9: winning score, 1..15.
- CLR_CYC, 2: cycles Sel_RSTn is held low per clear, ≥1.

- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- Host_Start  in  1  one-cycle pulse: open a round.
- Host_Correct  in  1  one-cycle pulse: current answer correct.
- Host_Wrong  in  1  one-cycle pulse: current answer wrong.
- Host_Clear  in  1  one-cycle pulse: abort round / new game.
- Sel_Lock  in  1  selector has latched a player (its Timer_Start).
- Sel_Player  in  4  selector Player_Number, valid 1..4.
- Sel_Start  out  1  arm selector.
- Sel_RSTn  out  1  active-low clear to selector.
- Round_State  out  3  current FSM state code.
- Cur_Player  out  4  player answering, 0 if none.
- Sec_Left  out  4  countdown seconds remaining.
- Score  out  16  four 4-bit scores, player 1 in [3:0] … player 4 in [15:12].
- Round_Cnt  out  8  completed rounds, wraps 255→0.
- Game_Over  out  1  a player reached SCORE_MAX.
- Winner  out  4  winning player, 0 until Game_Over.

## Operation
- States: IDLE, ARMED, ANSWER, CLEAR, OVER.
- Reset: state CLEAR with CLR_CYC counter loaded; Sel_Start=0, Sel_RSTn=0, Cur_Player=0, Sec_Left=0, Score=0, Round_Cnt=0, Game_Over=0, Winner=0.
- IDLE: Host_Start → ARMED. Other host inputs are ignored.
- ARMED: Sel_Start=1. Sel_Lock=1 with Sel_Player in 1..4 → ANSWER: capture Cur_Player, load Sec_Left=ANSWER_SEC, zero the prescaler. Sel_Lock with an invalid Sel_Player → CLEAR, no score change. Host_Clear → CLEAR.
- ANSWER: Sel_Start stays 1.
  - Host_Correct alone: that player's score +1, saturating at SCORE_MAX.
  - Host_Wrong alone: that player's score −1, saturating at 0.
  - Countdown expiry: treated as Host_Wrong.
  - Each of the three: Round_Cnt +1, then CLEAR, or OVER if the new score equals SCORE_MAX.
  - Host_Correct and Host_Wrong in the same cycle: both ignored, state holds.
  - Host_Clear: overrides judgements and expiry in the same cycle → CLEAR, no score or Round_Cnt change.
- CLEAR: Sel_Start=0, Sel_RSTn=0 for exactly CLR_CYC cycles. Cur_Player=0, Sec_Left=0. Then → IDLE.
- OVER: Game_Over=1, Winner=Cur_Player, Sel_Start=0, Sel_RSTn=1 (selector stays latched). Host_Clear → zero Score, Round_Cnt, Game_Over and Winner, then → CLEAR. All else ignored.
- Sel_RSTn=1 in every state except CLEAR.

## Timing
- All outputs are registered. State changes one cycle after the qualifying input is sampled.
- Sel_Start rises the cycle after Host_Start is sampled in IDLE.
- Lock to ANSWER: 1 cycle. Cur_Player is valid in the first ANSWER cycle.
- Countdown: the prescaler counts 0..TICK_DIV−1. At wrap, Sec_Left decrements. The wrap taking Sec_Left from 1 to 0 is expiry. Expiry occurs exactly ANSWER_SEC×TICK_DIV cycles after ANSWER entry.
- A judgement in the same cycle as expiry takes precedence; expiry is dropped.
- Score updates and Round_Cnt increment are visible in the first CLEAR/OVER cycle.
- RST asserted in any state forces the reset values immediately and asynchronously. Deassertion is followed by the CLR_CYC clear.

## Structure
- Shared package quiz_pkg:
  - state encoding constants: IDLE=0, ARMED=1, ANSWER=2, CLEAR=3, OVER=4;
  - player ID constants, NUM_PLAYERS=4;
  - score width 4.
- One sub-module, sec_tick_gen: prescaler with sync clear input and a one-cycle tick output, parameter TICK_DIV. All remaining logic, including the FSM and the score array, stays in the top level.

## Test plan
All scenarios use TICK_DIV=4, ANSWER_SEC=3, SCORE_MAX=2, CLR_CYC=2.
- Reset release → Sel_RSTn low 2 cycles, then IDLE with all outputs 0 and Sel_RSTn=1.
- Host_Start, Sel_Lock with Sel_Player=3, Host_Correct → Score=16'h0100, Round_Cnt=1, Sel_RSTn low 2 cycles, then IDLE.
- Lock player 2 with no judgement → Sec_Left steps 3,2,1 every 4 cycles. Expiry 12 cycles after ANSWER entry; player 2 score stays 0 (saturation). Round_Cnt +1.
- Host_Correct and Host_Wrong in the same cycle → state and scores unchanged. A following Host_Correct alone is applied.
- Player 1 correct twice → OVER, Game_Over=1, Winner=1, Score=16'h0002. Host_Start ignored. Host_Clear → scores 0, then CLEAR, then IDLE.
- Sel_Lock with Sel_Player=0 → CLEAR with no score change. RST pulsed mid-ANSWER → all outputs back to reset values immediately.
